bcd_binary_design: RTL and testbench

Sequential BCD-to-binary converter: accepts three BCD digits (hundreds, tens, ones), converts them to an 8-bit unsigned binary value with a reverse double-dabble engine (shift right, then subtract-3 correction), and flags out-of-range or malformed input. It is the inverse of `binary_BCD_design` and sits on the input side of the display/entry path, turning digit-entry values back into the binary operand domain. A start/done handshake allows one conversion at a time.

---
 rtl/bcd_binary_design_if.sv | 30 +++
 rtl/bcd_binary_design.sv | 118 +++++++++++
 tb/tb_bcd_binary_design.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_binary_design_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
//   start                 : request a conversion (sampled only while idle)
//   Hundreds, Tens, Ones  : BCD digits, captured together with start
//   binary                : converted 8-bit value, held until the next done
//   busy                  : conversion in progress
//   done                  : one-cycle result strobe
//   overflow              : value exceeded 255, binary saturated to 8'hFF
//   invalid               : a captured digit exceeded 9, binary forced to 0
// The master drives the request side; the slave is the converter.
interface bcd_binary_design_if;
  logic       start;
  logic [3:0] Hundreds;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic [7:0] binary;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       invalid;

  modport master (
    output start, Hundreds, Tens, Ones,
    input  binary, busy, done, overflow, invalid
  );

  modport slave (
    input  start, Hundreds, Tens, Ones,
    output binary, busy, done, overflow, invalid
  );
endinterface

// File: rtl/bcd_binary_design.sv
// Sequential three-digit BCD to 8-bit binary converter using reverse
// double-dabble: ten iterations of "shift {bcd, result} right by one, then
// subtract 3 from every BCD digit that is 8 or more".
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any conversion in flight
//   bus   : slave side of bcd_binary_design_if (start/digits in,
//           binary/busy/done/overflow/invalid out, all outputs registered)
// Valid input: done arrives 11 cycles after start is sampled.
// Malformed input (a digit above 9): done + invalid arrive one cycle later.
module bcd_binary_design (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_binary_design_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] bcd;
  logic [9:0]  result;
  logic [3:0]  count;

  logic [21:0] shifted;
  logic [11:0] bcd_next;
  logic [9:0]  result_next;
  logic        digit_bad;

  assign digit_bad = (bus.Hundreds > 4'd9) || (bus.Tens > 4'd9) || (bus.Ones > 4'd9);

  // One reverse double-dabble step. A digit that received a shifted-in 1
  // in its MSB reads 8 + x; correcting by 3 yields 5 + x, i.e. the proper
  // BCD halving of (10 + 2x) carried down from the digit above.
  always_comb begin
    // NOTE: every combinational output gets a value before any conditional
    // update, so no path can leave it unassigned and infer a latch.
    shifted     = {bcd, result} >> 1;
    result_next = shifted[9:0];
    bcd_next    = shifted[21:10];
    for (int i = 0; i < 3; i++) begin
      if (bcd_next[4*i +: 4] >= 4'd8) begin
        bcd_next[4*i +: 4] = bcd_next[4*i +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including datapath state, is cleared by reset so
    // an aborted conversion cannot leak partial values into the next one.
    if (!rst_n) begin
      state        <= IDLE;
      bcd          <= '0;
      result       <= '0;
      count        <= '0;
      bus.binary   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.invalid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bcd    <= {bus.Hundreds, bus.Tens, bus.Ones};
            result <= '0;
            count  <= '0;
            if (digit_bad) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.invalid  <= 1'b1;
              bus.overflow <= 1'b0;
              bus.binary   <= '0;
            end else begin
              state    <= SHIFT;
              bus.busy <= 1'b1;
            end
          end
        end

        SHIFT: begin
          bcd    <= bcd_next;
          result <= result_next;
          count  <= count + 4'd1;
          if (count == 4'd9) begin
            // Outputs are loaded from the final iteration's result directly,
            // so they change exactly on the edge that enters DONE.
            state       <= DONE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.invalid <= 1'b0;
            if (result_next > 10'd255) begin
              bus.overflow <= 1'b1;
              bus.binary   <= 8'hFF;
            end else begin
              bus.overflow <= 1'b0;
              bus.binary   <= result_next[7:0];
            end
          end
        end

        DONE: begin
          // start is deliberately ignored here; the next capture happens
          // from IDLE on the following edge at the earliest.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_binary_design.sv
// Self-checking bench for bcd_binary_design: table-driven conversions with a
// scoreboard queue, random vectors against a decimal model, and hand-written
// sequences for ignored start, held start, and asynchronous reset.
module tb_bcd_binary_design;

  logic clk;
  logic rst_n;

  bcd_binary_design_if bus ();

  bcd_binary_design dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] bin;
    logic       ovf;
    logic       inv;
  } vec_t;

  typedef struct {
    logic [7:0] bin;
    logic       ovf;
    logic       inv;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent decimal reference for arbitrary digits.
  function automatic exp_t model(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    exp_t e;
    int   v;
    v     = int'(h) * 100 + int'(t) * 10 + int'(o);
    e.inv = (h > 4'd9) || (t > 4'd9) || (o > 4'd9);
    e.ovf = !e.inv && (v > 255);
    e.bin = e.inv ? 8'h00 : (e.ovf ? 8'hFF : v[7:0]);
    return e;
  endfunction

  // Pulse start with the given digits, push the expectation, then wait a
  // bounded number of cycles for done and compare against the popped entry.
  task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input exp_t e, input string tag);
    int   cycles;
    int   busy_cnt;
    bit   got;
    int   exp_lat;
    exp_t x;
    exp_lat = e.inv ? 1 : 11;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Hundreds = h;
    bus.Tens     = t;
    bus.Ones     = o;
    sb.push_back(e);
    cycles   = 0;
    busy_cnt = 0;
    got      = 0;
    while (cycles < 40 && !got) begin
      @(negedge clk);
      bus.start    = 1'b0;
      // Digits are scrambled after capture; the DUT must not re-sample them.
      bus.Hundreds = 4'hF;
      bus.Tens     = 4'hE;
      bus.Ones     = 4'hD;
      cycles++;
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", tag);
      sb.delete();
    end else begin
      x = sb.pop_front();
      check({tag, "_binary"},   32'(bus.binary),   32'(x.bin));
      check({tag, "_overflow"}, 32'(bus.overflow), 32'(x.ovf));
      check({tag, "_invalid"},  32'(bus.invalid),  32'(x.inv));
      check({tag, "_latency"},  32'(cycles),       32'(exp_lat));
      check({tag, "_busy_cyc"}, 32'(busy_cnt),     e.inv ? 32'd0 : 32'd10);
      @(negedge clk);
      check({tag, "_done_1cyc"}, 32'(bus.done),    32'd0);
      check({tag, "_held"},      32'(bus.binary),  32'(x.bin));
    end
  endtask

  initial begin
    vec_t vecs[10];
    exp_t e;
    int   cycles;
    bit   got;
    int   done_cnt;
    int   last;
    int   dbl;
    logic prev_done;

    vecs[0] = '{h: 4'd0, t: 4'd4,  o: 4'd7, bin: 8'h2F, ovf: 1'b0, inv: 1'b0};
    vecs[1] = '{h: 4'd2, t: 4'd0,  o: 4'd9, bin: 8'hD1, ovf: 1'b0, inv: 1'b0};
    vecs[2] = '{h: 4'd2, t: 4'd5,  o: 4'd5, bin: 8'hFF, ovf: 1'b0, inv: 1'b0};
    vecs[3] = '{h: 4'd0, t: 4'd0,  o: 4'd0, bin: 8'h00, ovf: 1'b0, inv: 1'b0};
    vecs[4] = '{h: 4'd2, t: 4'd5,  o: 4'd6, bin: 8'hFF, ovf: 1'b1, inv: 1'b0};
    vecs[5] = '{h: 4'd9, t: 4'd9,  o: 4'd9, bin: 8'hFF, ovf: 1'b1, inv: 1'b0};
    vecs[6] = '{h: 4'd1, t: 4'hA,  o: 4'd3, bin: 8'h00, ovf: 1'b0, inv: 1'b1};
    vecs[7] = '{h: 4'd0, t: 4'd4,  o: 4'd7, bin: 8'h2F, ovf: 1'b0, inv: 1'b0};
    vecs[8] = '{h: 4'd1, t: 4'd2,  o: 4'd8, bin: 8'h80, ovf: 1'b0, inv: 1'b0};
    vecs[9] = '{h: 4'd0, t: 4'd9,  o: 4'hF, bin: 8'h00, ovf: 1'b0, inv: 1'b1};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.Hundreds = 4'd0;
    bus.Tens     = 4'd0;
    bus.Ones     = 4'd0;
    #1;
    check("rst_binary",   32'(bus.binary),   32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_invalid",  32'(bus.invalid),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors (includes invalid followed by valid).
    for (int i = 0; i < 10; i++) begin
      e.bin = vecs[i].bin;
      e.ovf = vecs[i].ovf;
      e.inv = vecs[i].inv;
      convert(vecs[i].h, vecs[i].t, vecs[i].o, e, $sformatf("vec%0d", i));
    end

    // Random digits (0..11 so some are malformed) against the decimal model.
    for (int i = 0; i < 6; i++) begin
      logic [3:0] h, t, o;
      h = 4'($urandom_range(0, 11));
      t = 4'($urandom_range(0, 11));
      o = 4'($urandom_range(0, 11));
      convert(h, t, o, model(h, t, o), $sformatf("rnd%0d", i));
    end

    // start during SHIFT is ignored: 1,2,3 then 9,9,9 pulsed at cycle 4.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Hundreds = 4'd1;
    bus.Tens     = 4'd2;
    bus.Ones     = 4'd3;
    e = model(4'd1, 4'd2, 4'd3);
    sb.push_back(e);
    cycles = 0;
    got    = 0;
    while (cycles < 40 && !got) begin
      @(negedge clk);
      cycles++;
      bus.start    = (cycles == 3);
      bus.Hundreds = 4'd9;
      bus.Tens     = 4'd9;
      bus.Ones     = 4'd9;
      if (bus.done) got = 1;
    end
    bus.start = 1'b0;
    check("ign_got_done", 32'(got), 32'd1);
    if (got) begin
      e = sb.pop_front();
      check("ign_binary",  32'(bus.binary), 32'(e.bin));
      check("ign_latency", 32'(cycles),     32'd11);
    end else begin
      sb.delete();
    end
    dbl = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dbl++;
    end
    check("ign_no_extra", 32'(dbl), 32'd0);

    // start held high: captures every 12 cycles, single-cycle done each time.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Hundreds = 4'd2;
    bus.Tens     = 4'd5;
    bus.Ones     = 4'd6;
    done_cnt  = 0;
    last      = 0;
    dbl       = 0;
    prev_done = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (prev_done) dbl++;
        if (done_cnt == 0) check("held_first_lat", 32'(i), 32'd11);
        else               check("held_spacing", 32'(i - last), 32'd12);
        check("held_ovf", 32'(bus.overflow), 32'd1);
        last = i;
        done_cnt++;
      end
      prev_done = bus.done;
    end
    check("held_done_count", 32'(done_cnt), 32'd3);
    check("held_no_double",  32'(dbl),      32'd0);
    bus.start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1;
    end
    check("held_drain", 32'(got), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-conversion; outputs currently FF/overflow.
    bus.start    = 1'b1;
    bus.Hundreds = 4'd0;
    bus.Tens     = 4'd4;
    bus.Ones     = 4'd7;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_binary",   32'(bus.binary),   32'd0);
    check("arst_busy",     32'(bus.busy),     32'd0);
    check("arst_done",     32'(bus.done),     32'd0);
    check("arst_overflow", 32'(bus.overflow), 32'd0);
    check("arst_invalid",  32'(bus.invalid),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dbl = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dbl++;
    end
    check("arst_no_done", 32'(dbl), 32'd0);
    convert(4'd2, 4'd0, 4'd9, model(4'd2, 4'd0, 4'd9), "post_rst");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
